hash_rate_meter: RTL
====================

# hash_rate_meter

Measures the throughput of the cryptography core: counts per-operation completion pulses over a window of one or more `second_tick` pulses from the upstream one-second timer, then presents the count through a valid/ready interface to the reporting stage. Sits directly downstream of the timer and beside the core's `op_done` output. It feeds the status/UART reporting path.

## Interface
- `COUNT_W`, 32: width of the operation counter and `rate_data`.
- `WINDOW_TICKS`, 1: `second_tick` pulses per measurement window; legal range 1..255.
- `clk`  in  1  clock.
- `n_rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  measurement enable, level.
- `second_tick`  in  1  one-cycle pulse from the upstream timer.
- `op_done`  in  1  one-cycle pulse per completed core operation.
- `rate_data`  out  COUNT_W  operations counted in the last completed window.
- `rate_ovf`  out  1  `rate_data` saturated; qualified by `rate_valid`.
- `rate_valid`  out  1  result available.
- `rate_ready`  in  1  consumer accepts the result.
- `rate_drop`  out  1  sticky: a window result was discarded because the output was still held.
- `peak_data`  out  COUNT_W  highest accepted `rate_data` since last clear (macro only).
- `peak_clear`  in  1  synchronous clear of `peak_data` (macro only).

## Operation
- States: IDLE, ARM, COUNT.
- IDLE: counters held at 0. `enable` = 1 moves the block to ARM on the next cycle.
- ARM: discards the partial window. The first `second_tick` clears `op_cnt` and `tick_cnt` and moves the block to COUNT.
- COUNT:
  - Each `op_done` increments `op_cnt`. The count saturates at all-ones and sets the internal `ovf` flag.
  - Each `second_tick` increments `tick_cnt`.
  - The tick for which `tick_cnt == WINDOW_TICKS-1` closes the window.
- Window close:
  - If the output register is free, or is being accepted this cycle (`rate_valid && rate_ready`), load `op_cnt` (including any `op_done` in the same cycle) and `ovf` into `rate_data` and `rate_ovf`, and set `rate_valid`.
  - Otherwise, discard the result and set `rate_drop`.
  - In both cases, `op_cnt`, `ovf` and `tick_cnt` restart from 0. An `op_done` in the closing cycle belongs to the closing window.
- `enable` = 0 in any state:
  - Next state is IDLE and the counters clear.
  - A pending `rate_valid` stays high until accepted; the handshake is never withdrawn.
  - `rate_drop` clears on the IDLE → ARM transition.
- Handshake:
  - `rate_data` and `rate_ovf` are stable while `rate_valid && !rate_ready`.
  - A transfer happens on any cycle with `rate_valid && rate_ready`.

## Timing
- Reset values: all outputs 0; state IDLE.
- Latency:
  - From the closing `second_tick` sampled in cycle N, `rate_valid` and `rate_data` are visible from cycle N+1.
  - After a transfer in cycle M with no new close, `rate_valid` is 0 in cycle M+1.
  - If a transfer and a window close coincide, `rate_valid` stays 1 and the data updates.
- ARM to COUNT: first window spans exactly `WINDOW_TICKS` ticks after the arming tick.
- `n_rst` mid-window: immediate return to reset values; partial counts are lost.
- Saturation: `op_cnt` never wraps. `rate_ovf` = 1 exactly when the window reached 2^COUNT_W−1 with at least one further `op_done`.

## Configuration
- `HASH_RATE_PEAK_EN` defined:
  - `peak_data` and `peak_clear` exist.
  - On each transfer with `rate_data > peak_data`, `peak_data` updates the next cycle.
  - `peak_clear` zeroes it the next cycle and wins over a simultaneous update.
  - `peak_data` is not affected by `enable`.
- Not defined: both ports and the comparator are absent; all other behaviour is identical.

## Structure
- Package `hash_rate_pkg`: `meter_state_t` enum {IDLE, ARM, COUNT}, `RATE_COUNT_W_DEFAULT` = 32, `RATE_WINDOW_MAX` = 255.
- Sub-module `sat_counter`: parameterised width, with inputs `clear` and `inc` and outputs `count` and `sat`. Used for `op_cnt`.

## Test plan
- Reset mid-count with `COUNT_W`=32, `WINDOW_TICKS`=1: all outputs 0, state IDLE, and no `rate_valid` until re-armed.
- Basic window: `enable`, arming tick, then 37 `op_done`, then a tick (`rate_ready`=1) → `rate_data`=37, `rate_valid` for 1 cycle, `rate_ovf`=0.
- Tick coinciding with `op_done`:
  - 10 ops, with the 10th in the same cycle as the closing tick → `rate_data`=10.
  - The next window starts at 0.
- Backpressure with `rate_ready`=0 across two closes:
  - First result (5) is held stable and `rate_drop`=1 after the second close.
  - Asserting `rate_ready` transfers 5.
  - Close plus transfer in the same cycle keeps `rate_valid`=1 with the new value.
- Saturation with `COUNT_W`=4: 20 ops in one window → `rate_data`=15, `rate_ovf`=1.
- `WINDOW_TICKS`=3 with `HASH_RATE_PEAK_EN`:
  - Windows of 30 then 12 ops → `peak_data`=30.
  - `peak_clear` → 0.
  - `enable` drop with `rate_valid` pending keeps `rate_valid` until accepted.

Source files
------------

// File: rtl/hash_rate_pkg.sv
// Shared types and limits for the hash rate meter.
// Pure declarations, no logic.
// Imported by the meter top and its testbench.
package hash_rate_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } meter_state_t;

  localparam int RATE_COUNT_W_DEFAULT = 32;
  localparam int RATE_WINDOW_MAX      = 255;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky flag for an increment attempted at all-ones.
// Latency: count/sat reflect clear/inc one cycle later.
// Backpressure: none; clear has priority over inc.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  logic [W-1:0] count_q, count_d;
  logic         sat_q, sat_d;

  // Next count: clear wins; at all-ones the value holds and the flag is raised.
  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clear) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (inc) begin
      if (&count_q) begin
        sat_d = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/hash_rate_meter.sv
// Counts op_done pulses per window of WINDOW_TICKS second_ticks; optional peak tracker (HASH_RATE_PEAK_EN).
// Latency: result visible the cycle after the closing tick.
// Backpressure: result held until rate_ready; a close while held is discarded and sets sticky rate_drop.
module hash_rate_meter
  import hash_rate_pkg::*;
#(
  parameter int COUNT_W      = RATE_COUNT_W_DEFAULT,
  parameter int WINDOW_TICKS = 1
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               enable,
  input  logic               second_tick,
  input  logic               op_done,
  output logic [COUNT_W-1:0] rate_data,
  output logic               rate_ovf,
  output logic               rate_valid,
  input  logic               rate_ready,
  output logic               rate_drop
`ifdef HASH_RATE_PEAK_EN
  ,
  output logic [COUNT_W-1:0] peak_data,
  input  logic               peak_clear
`endif
);

  localparam logic [7:0] LAST_TICK = 8'(WINDOW_TICKS - 1);

  meter_state_t       state_q, state_d;
  logic [7:0]         tick_cnt_q, tick_cnt_d;
  logic [COUNT_W-1:0] rate_data_q, rate_data_d;
  logic               rate_ovf_q, rate_ovf_d;
  logic               rate_valid_q, rate_valid_d;
  logic               rate_drop_q, rate_drop_d;

  logic               cnt_clear, cnt_inc, close;
  logic [COUNT_W-1:0] op_cnt;
  logic               op_sat, op_at_max;
  logic [COUNT_W-1:0] close_cnt;
  logic               close_ovf;
  logic               xfer, out_free;

  sat_counter #(.W(COUNT_W)) u_op_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (op_cnt),
    .sat   (op_sat)
  );

  // The closing cycle's op_done belongs to the closing window, so fold it in here
  // while the counter itself restarts from zero.
  assign op_at_max = &op_cnt;
  assign close_cnt = (op_done && !op_at_max) ? op_cnt + COUNT_W'(1) : op_cnt;
  assign close_ovf = op_sat | (op_done & op_at_max);
  assign xfer      = rate_valid_q & rate_ready;
  assign out_free  = ~rate_valid_q | rate_ready;

  // Window FSM: arm on the first tick, count ops and ticks, close on the last tick.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    cnt_clear  = 1'b1;
    cnt_inc    = 1'b0;
    close      = 1'b0;
    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        if (enable) state_d = ARM;
      end
      ARM: begin
        tick_cnt_d = '0;
        if (!enable) state_d = IDLE;
        else if (second_tick) state_d = COUNT;
      end
      COUNT: begin
        if (!enable) begin
          state_d    = IDLE;
          tick_cnt_d = '0;
        end else begin
          cnt_clear = 1'b0;
          cnt_inc   = op_done;
          if (second_tick) begin
            if (tick_cnt_q == LAST_TICK) begin
              close      = 1'b1;
              cnt_clear  = 1'b1;
              tick_cnt_d = '0;
            end else begin
              tick_cnt_d = tick_cnt_q + 8'd1;
            end
          end
        end
      end
      default: begin
        state_d    = IDLE;
        tick_cnt_d = '0;
      end
    endcase
  end

  // Output register: never withdraw a pending result; load on close only if free or draining.
  always_comb begin
    rate_data_d  = rate_data_q;
    rate_ovf_d   = rate_ovf_q;
    rate_valid_d = rate_valid_q;
    rate_drop_d  = rate_drop_q;
    if (xfer) rate_valid_d = 1'b0;
    if (close) begin
      if (out_free) begin
        rate_data_d  = close_cnt;
        rate_ovf_d   = close_ovf;
        rate_valid_d = 1'b1;
      end else begin
        rate_drop_d = 1'b1;
      end
    end
    if (state_q == IDLE && enable) rate_drop_d = 1'b0;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      rate_data_q  <= '0;
      rate_ovf_q   <= 1'b0;
      rate_valid_q <= 1'b0;
      rate_drop_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      rate_data_q  <= rate_data_d;
      rate_ovf_q   <= rate_ovf_d;
      rate_valid_q <= rate_valid_d;
      rate_drop_q  <= rate_drop_d;
    end
  end

  assign rate_data  = rate_data_q;
  assign rate_ovf   = rate_ovf_q;
  assign rate_valid = rate_valid_q;
  assign rate_drop  = rate_drop_q;

`ifdef HASH_RATE_PEAK_EN
  logic [COUNT_W-1:0] peak_q, peak_d;

  // Peak of accepted results; clear wins over a simultaneous update.
  always_comb begin
    peak_d = peak_q;
    if (peak_clear) peak_d = '0;
    else if (xfer && (rate_data_q > peak_q)) peak_d = rate_data_q;
  end

  // Peak register, independent of enable.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) peak_q <= '0;
    else       peak_q <= peak_d;
  end

  assign peak_data = peak_q;
`endif

endmodule
